// File: rtl/csa_frame_accumulator.sv
// Purpose : accumulates a frame of operands in carry-save form and returns one resolved sum per frame.
// Latency : out_valid rises NCH+1 cycles after the last beat is accepted (6 cycles with the defaults).
// Backpressure: in_ready is low from the last beat until the result is taken; the result holds while out_ready=0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   approx_en         approximate mode select, sampled on the first beat of a frame only
//   in_valid/in_ready operand beat handshake; in_data operand, in_last marks the final beat
//   out_valid/out_ready result handshake; out_sum frame sum modulo 2^ACC_WIDTH
//   out_overflow      frame sum reached 2^ACC_WIDTH (meaningful only with out_valid)
//   busy              a frame is in progress or a result is pending
module csa_frame_accumulator #(
   parameter int WIDTH       = 8,
   parameter int ACC_WIDTH   = 20,
   parameter int APPROX_BITS = 4,
   parameter int CHUNK       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 approx_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_overflow,
   output logic                 busy
);

   localparam int NCH   = (ACC_WIDTH + CHUNK - 1) / CHUNK;
   // number of real result bits held in the most significant chunk
   localparam int LASTW = ACC_WIDTH - (NCH - 1) * CHUNK;
   // counter spans 0..NCH: NCH chunk steps plus one publish step
   localparam int KW    = $clog2(NCH + 1);

   localparam logic [KW-1:0]        KLAST   = KW'(NCH - 1);
   localparam logic [KW-1:0]        KPUB    = KW'(NCH);
   localparam logic [ACC_WIDTH-1:0] LOWMASK = (ACC_WIDTH'(1) << APPROX_BITS) - ACC_WIDTH'(1);
   localparam logic [ACC_WIDTH-1:0] CMASK   = (ACC_WIDTH'(1) << CHUNK) - ACC_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;

   state_t                state;
   logic [ACC_WIDTH-1:0]  s;          // carry-save sum vector
   logic [ACC_WIDTH-1:0]  c;          // carry-save carry vector
   logic [ACC_WIDTH-1:0]  res;        // resolved sum under construction
   logic                  mode;       // approximate mode latched for the current frame
   logic                  ovf;        // sticky overflow for the current frame
   logic                  rcarry;     // ripple carry between chunks
   logic [KW-1:0]         kcnt;       // RESOLVE step counter

   logic                  beat;
   logic [ACC_WIDTH-1:0]  x;
   logic [ACC_WIDTH-1:0]  amask;
   logic [ACC_WIDTH-1:0]  csa_sum;
   logic [ACC_WIDTH-1:0]  csa_maj;
   logic [CHUNK-1:0]      chunk_a;
   logic [CHUNK-1:0]      chunk_b;
   logic [CHUNK:0]        chunk_sum;
   logic [ACC_WIDTH-1:0]  chunk_ins;
   logic [ACC_WIDTH-1:0]  chunk_msk;
   logic                  last_carry;

   assign in_ready = rst_n & ((state == IDLE) | (state == ACCUM));
   assign busy     = (state != IDLE);
   assign beat     = in_valid & in_ready;
   assign x        = ACC_WIDTH'(in_data);

   // Full-adder column array. Approximated columns OR their inputs and
   // never produce a carry, so nothing crosses into column APPROX_BITS.
   always_comb begin
      amask   = mode ? LOWMASK : '0;
      csa_sum = ((s ^ c ^ x) & ~amask) | ((s | c | x) & amask);
      csa_maj = ((s & c) | (s & x) | (c & x)) & ~amask;
   end

   // One CHUNK-wide slice of the exact S + C ripple, selected by kcnt.
   // Bits above ACC_WIDTH shift in as zero, so a partial top chunk needs
   // no special casing except where its carry-out lands.
   always_comb begin
      chunk_a    = CHUNK'(s >> (CHUNK * kcnt));
      chunk_b    = CHUNK'(c >> (CHUNK * kcnt));
      chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, rcarry};
      chunk_ins  = ACC_WIDTH'(chunk_sum[CHUNK-1:0]) << (CHUNK * kcnt);
      chunk_msk  = CMASK << (CHUNK * kcnt);
      // carry out of the real MSB sits at bit LASTW of the top chunk
      last_carry = |(chunk_sum >> LASTW);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         s            <= '0;
         c            <= '0;
         res          <= '0;
         out_sum      <= '0;
         rcarry       <= 1'b0;
         out_valid    <= 1'b0;
         out_overflow <= 1'b0;
         ovf          <= 1'b0;
         mode         <= 1'b0;
         kcnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (beat) begin
                  s      <= x;
                  c      <= '0;
                  ovf    <= 1'b0;
                  mode   <= approx_en;
                  rcarry <= 1'b0;
                  kcnt   <= '0;
                  state  <= in_last ? RESOLVE : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  s <= csa_sum;
                  c <= csa_maj << 1;
                  // a carry out of the top column has weight 2^ACC_WIDTH
                  if (csa_maj[ACC_WIDTH-1]) ovf <= 1'b1;
                  if (in_last) state <= RESOLVE;
               end
            end
            RESOLVE: begin
               if (kcnt == KPUB) begin
                  // final step publishes the result so out_sum only moves once per frame
                  out_sum      <= res;
                  out_overflow <= ovf;
                  out_valid    <= 1'b1;
                  state        <= HOLD;
               end else begin
                  res    <= (res & ~chunk_msk) | chunk_ins;
                  rcarry <= chunk_sum[CHUNK];
                  if ((kcnt == KLAST) && last_carry) ovf <= 1'b1;
                  kcnt   <= kcnt + KW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
